mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, variable-latency data/instruction memory between the instruction-fetch stage and the load/store unit of the pipelined RV32I core. Grants one access at a time, prioritising LSU (older instruction) with an anti-starvation limit for fetch. Performs store lane steering and byte-mask generation, and load byte/half extraction with sign/zero extension, from the 3-bit memory access type (funct3). Detects misaligned accesses without touching memory.

## Interface
- MAX_LSU_STREAK, 4, consecutive LSU grants allowed while fetch is pending before fetch is forced.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_if_req  in  1  fetch request; held with i_if_addr until o_if_gnt.
- i_if_addr  in  32  fetch word address (bits [1:0] ignored).
- o_if_gnt  out  1  fetch request accepted this cycle.
- o_if_rvalid  out  1  fetch data valid (one-cycle pulse).
- o_if_rdata  out  32  fetch data.
- i_ls_req  in  1  LSU request; held with all i_ls_* until o_ls_gnt.
- i_ls_we  in  1  0: load; 1: store.
- i_ls_addr  in  32  byte address.
- i_ls_wdata  in  32  store data, right-aligned.
- i_ls_type_access  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- o_ls_gnt  out  1  LSU request accepted this cycle.
- o_ls_rvalid  out  1  load data returned / store completed (pulse).
- o_ls_rdata  out  32  extended load data; 0 for stores.
- o_ls_err  out  1  misaligned-access pulse, coincident with o_ls_gnt.
- o_mem_req  out  1  memory access strobe.
- o_mem_we  out  1  memory write.
- o_mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_mem_wdata  out  32  lane-steered store data.
- o_mem_bmask  out  4  byte-enable mask.
- i_mem_rvalid  in  1  memory completion pulse (reads and writes).
- i_mem_rdata  in  32  memory read word.
- o_busy  out  1  access outstanding.

## Operation
- States: IDLE, IF_BUSY, LS_BUSY.
- IDLE arbitration (combinational): LSU wins if i_ls_req and (!i_if_req or streak < MAX_LSU_STREAK); else fetch wins if i_if_req.
- Winner's gnt, o_mem_req and mem address/data/mask are driven combinationally in the grant cycle; state becomes IF_BUSY/LS_BUSY at the next edge; addr[1:0] and type_access are registered.
- Streak counter: increments on LSU grant while i_if_req=1, saturates at MAX_LSU_STREAK, clears on fetch grant or when i_if_req=0.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. Response: o_ls_gnt=1, o_ls_err=1, no o_mem_req, stay IDLE, streak unchanged; fetch is not granted that cycle.
- Store: B replicates wdata[7:0] to all lanes, mask 0001<<addr[1:0]; H replicates wdata[15:0], mask 0011<<{addr[1],0}; W mask 1111.
- Load: select byte/half by registered addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
- BUSY: wait for i_mem_rvalid; in that cycle pulse the owner's rvalid with formatted rdata (combinational from i_mem_rdata), return to IDLE next edge.
- i_mem_rvalid in IDLE is ignored (never forwarded).

## Timing
- Reset: state IDLE, streak 0; all outputs 0.
- Minimum access: grant cycle N, rvalid at N+k (k≥1 = memory latency); next grant earliest N+k+1.
- One outstanding access; no request accepted outside IDLE.
- Reset asserted mid-access: immediate return to IDLE; late i_mem_rvalid dropped.
- Simultaneous i_if_req and i_ls_req in IDLE: rule above; equal-cycle arrival treated identically.

## Structure
- Shared package rv32i_pkg: access-type constants (LB, LH, LW, LBU, LHU, SB, SH, SW encodings) and the arbiter state enum.
- Sub-module lsu_data_align: combinational store steering/mask and load extraction/extension; arbiter holds FSM, streak counter, and registered addr/type.

## Test plan
- Fetch only, addr 0x104, latency 2, rdata 0xDEADBEEF -> gnt cycle 0, mem_addr 0x104, if_rvalid cycle 2 with 0xDEADBEEF.
- SB addr 0x203, wdata 0x000000A5 -> mem_wdata 0xA5A5A5A5, bmask 1000, we=1; ls_rvalid on completion, rdata 0.
- LB addr 0x202, mem word 0x0080FF11 -> rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 -> 0x00000080.
- LW addr 0x102 -> ls_gnt=1, ls_err=1, no mem_req, state stays IDLE.
- Both requesting continuously, MAX_LSU_STREAK=4 -> grant order LS,LS,LS,LS,IF, repeat.
- Reset pulled mid LS_BUSY, then i_mem_rvalid -> all outputs 0, no ls_rvalid, next fetch request granted normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: memory access-type encodings (funct3) and arbiter state.
package rv32i_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_BUSY = 2'b01,
        LS_BUSY = 2'b10
    } arb_state_e;

    // funct3[1:0] carries the access size: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [1:0] offset, input logic [2:0] type_access);
        logic bad;
        bad = 1'b0;
        case (type_access[1:0])
            2'b01:   bad = offset[0];
            2'b10:   bad = (offset != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Store lane steering / byte-mask generation and load byte/half extraction with extension.
module lsu_data_align
    import rv32i_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [2:0]  st_type,
    input  logic [31:0] st_data,
    output logic [31:0] st_lanes,
    output logic [3:0]  st_bmask,
    input  logic [1:0]  ld_offset,
    input  logic [2:0]  ld_type,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_lanes = '0;
        st_bmask = '0;
        case (st_type[1:0])
            2'b00: begin
                st_lanes = {4{st_data[7:0]}};
                st_bmask = 4'b0001 << st_offset;
            end
            2'b01: begin
                st_lanes = {2{st_data[15:0]}};
                st_bmask = 4'b0011 << {st_offset[1], 1'b0};
            end
            default: begin
                st_lanes = st_data;
                st_bmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = '0;
        case (ld_offset)
            2'b00:   ld_byte = ld_word[7:0];
            2'b01:   ld_byte = ld_word[15:8];
            2'b10:   ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        ld_data = ld_word;
        case (ld_type)
            LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
            LH:      ld_data = {{16{ld_half[15]}}, ld_half};
            LBU:     ld_data = {24'h000000, ld_byte};
            LHU:     ld_data = {16'h0000, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and LSU: LSU priority with a
// bounded streak so fetch cannot starve, one outstanding access at a time.
module mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned MAX_LSU_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [2:0]  i_ls_type_access,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,
    output logic        o_ls_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    localparam int unsigned STREAK_W = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q;
    logic [1:0]          offset_q;
    logic [2:0]          type_q;
    logic                we_q;

    logic                ls_misaligned;
    logic [31:0]         st_lanes;
    logic [3:0]          st_bmask;
    logic [31:0]         ld_data;
    logic                unused_if_addr;

    assign unused_if_addr = ^i_if_addr[1:0];
    assign ls_misaligned  = is_misaligned(i_ls_addr[1:0], i_ls_type_access);
    assign o_busy         = (state_q != IDLE);

    lsu_data_align u_align (
        .st_offset (i_ls_addr[1:0]),
        .st_type   (i_ls_type_access),
        .st_data   (i_ls_wdata),
        .st_lanes  (st_lanes),
        .st_bmask  (st_bmask),
        .ld_offset (offset_q),
        .ld_type   (type_q),
        .ld_word   (i_mem_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Streak counts LSU wins only while fetch waits; a misaligned LSU reject never counts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            streak_q <= '0;
        end else if (!i_if_req || o_if_gnt) begin
            streak_q <= '0;
        end else if (o_ls_gnt && !o_ls_err && (streak_q < STREAK_MAX)) begin
            streak_q <= streak_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            offset_q <= '0;
            type_q   <= '0;
            we_q     <= 1'b0;
        end else if (o_ls_gnt && o_mem_req) begin
            offset_q <= i_ls_addr[1:0];
            type_q   <= i_ls_type_access;
            we_q     <= i_ls_we;
        end
    end

    always_comb begin
        state_d     = state_q;
        o_if_gnt    = 1'b0;
        o_if_rvalid = 1'b0;
        o_if_rdata  = '0;
        o_ls_gnt    = 1'b0;
        o_ls_rvalid = 1'b0;
        o_ls_rdata  = '0;
        o_ls_err    = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;

        case (state_q)
            IDLE: begin
                // Grants are combinational, so hold them off while reset is asserted.
                if (i_rst_n) begin
                    if (i_ls_req && (!i_if_req || (streak_q < STREAK_MAX))) begin
                        o_ls_gnt = 1'b1;
                        if (ls_misaligned) begin
                            o_ls_err = 1'b1;
                        end else begin
                            o_mem_req  = 1'b1;
                            o_mem_we   = i_ls_we;
                            o_mem_addr = {i_ls_addr[31:2], 2'b00};
                            if (i_ls_we) begin
                                o_mem_wdata = st_lanes;
                                o_mem_bmask = st_bmask;
                            end
                            state_d = LS_BUSY;
                        end
                    end else if (i_if_req) begin
                        o_if_gnt   = 1'b1;
                        o_mem_req  = 1'b1;
                        o_mem_addr = {i_if_addr[31:2], 2'b00};
                        state_d    = IF_BUSY;
                    end
                end
            end
            IF_BUSY: begin
                if (i_mem_rvalid) begin
                    o_if_rvalid = 1'b1;
                    o_if_rdata  = i_mem_rdata;
                    state_d     = IDLE;
                end
            end
            LS_BUSY: begin
                if (i_mem_rvalid) begin
                    o_ls_rvalid = 1'b1;
                    o_ls_rdata  = we_q ? '0 : ld_data;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_ls_req;
    logic        i_ls_we;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic [2:0]  i_ls_type_access;
    logic        o_ls_gnt;
    logic        o_ls_rvalid;
    logic [31:0] o_ls_rdata;
    logic        o_ls_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.MAX_LSU_STREAK(4)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_if_req         (i_if_req),
        .i_if_addr        (i_if_addr),
        .o_if_gnt         (o_if_gnt),
        .o_if_rvalid      (o_if_rvalid),
        .o_if_rdata       (o_if_rdata),
        .i_ls_req         (i_ls_req),
        .i_ls_we          (i_ls_we),
        .i_ls_addr        (i_ls_addr),
        .i_ls_wdata       (i_ls_wdata),
        .i_ls_type_access (i_ls_type_access),
        .o_ls_gnt         (o_ls_gnt),
        .o_ls_rvalid      (o_ls_rvalid),
        .o_ls_rdata       (o_ls_rdata),
        .o_ls_err         (o_ls_err),
        .o_mem_req        (o_mem_req),
        .o_mem_we         (o_mem_we),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .o_mem_bmask      (o_mem_bmask),
        .i_mem_rvalid     (i_mem_rvalid),
        .i_mem_rdata      (i_mem_rdata),
        .o_busy           (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"},
              {o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_ls_err, o_mem_req, o_mem_we, o_busy}, 0);
        check({tag, "_data"}, o_if_rdata | o_ls_rdata | o_mem_addr | o_mem_wdata, 0);
        check({tag, "_mask"}, o_mem_bmask, 0);
    endtask

    // Aligned LSU access with one-cycle memory latency.
    task automatic ls_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] typ,
                             input logic [31:0] word, input logic [31:0] exp_lanes,
                             input logic [3:0] exp_mask, input logic [31:0] exp_rdata);
        tick();
        i_ls_req = 1'b1; i_ls_we = we; i_ls_addr = addr;
        i_ls_wdata = wdata; i_ls_type_access = typ;
        #1;
        check({tag, "_gnt"}, {o_ls_gnt, o_ls_err, o_mem_req, o_if_gnt}, 4'b1010);
        check({tag, "_we"}, o_mem_we, we);
        check({tag, "_addr"}, o_mem_addr, addr & 32'hFFFF_FFFC);
        if (we) begin
            check({tag, "_wdata"}, o_mem_wdata, exp_lanes);
            check({tag, "_bmask"}, o_mem_bmask, exp_mask);
        end
        tick();
        i_ls_req = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = word;
        #1;
        check({tag, "_rvalid"}, {o_ls_rvalid, o_if_rvalid}, 2'b10);
        check({tag, "_rdata"}, o_ls_rdata, exp_rdata);
        tick();
        i_mem_rvalid = 1'b0;
    endtask

    task automatic ls_misalign(input string tag, input logic we, input logic [31:0] addr,
                               input logic [2:0] typ, input logic if_pending);
        tick();
        i_ls_req = 1'b1; i_ls_we = we; i_ls_addr = addr; i_ls_type_access = typ;
        i_if_req = if_pending; i_if_addr = 32'h0000_0700;
        #1;
        check({tag, "_resp"}, {o_ls_gnt, o_ls_err, o_mem_req, o_if_gnt}, 4'b1100);
        tick();
        i_ls_req = 1'b0; i_if_req = 1'b0;
        #1;
        check({tag, "_idle"}, {o_busy, o_ls_err, o_ls_rvalid}, 0);
    endtask

    logic [1:0] exp_seq [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

    initial begin
        logic [1:0] got;
        i_rst_n = 1'b0; i_if_req = 1'b0; i_if_addr = '0;
        i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_addr = '0; i_ls_wdata = '0;
        i_ls_type_access = '0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        repeat (2) tick();
        check_all_zero("reset");
        i_rst_n = 1'b1;

        // Fetch, latency 2
        tick();
        i_if_req = 1'b1; i_if_addr = 32'h0000_0104;
        #1;
        check("if_gnt", {o_if_gnt, o_mem_req, o_mem_we, o_ls_gnt}, 4'b1100);
        check("if_addr", o_mem_addr, 32'h0000_0104);
        tick();
        i_if_req = 1'b0;
        #1;
        check("if_wait", {o_busy, o_if_rvalid, o_mem_req}, 3'b100);
        tick();
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("if_rvalid", {o_if_rvalid, o_ls_rvalid}, 2'b10);
        check("if_rdata", o_if_rdata, 32'hDEAD_BEEF);
        tick();
        #1;
        check("idle_rvalid_ignored", {o_if_rvalid, o_ls_rvalid, o_busy}, 0);
        i_mem_rvalid = 1'b0;

        ls_access("sb", 1'b1, 32'h0000_0203, 32'h0000_00A5, 3'b000, 32'h0, 32'hA5A5_A5A5, 4'b1000, 32'h0);
        ls_access("sh", 1'b1, 32'h0000_0202, 32'h1234_BEEF, 3'b001, 32'h0, 32'hBEEF_BEEF, 4'b1100, 32'h0);
        ls_access("sw", 1'b1, 32'h0000_0100, 32'h1122_3344, 3'b010, 32'h0, 32'h1122_3344, 4'b1111, 32'h0);
        ls_access("lb", 1'b0, 32'h0000_0202, 32'h0, 3'b000, 32'h0080_FF11, 32'h0, 4'h0, 32'hFFFF_FF80);
        ls_access("lbu", 1'b0, 32'h0000_0202, 32'h0, 3'b100, 32'h0080_FF11, 32'h0, 4'h0, 32'h0000_0080);
        ls_access("lhu", 1'b0, 32'h0000_0202, 32'h0, 3'b101, 32'h0080_FF11, 32'h0, 4'h0, 32'h0000_0080);
        ls_access("lh", 1'b0, 32'h0000_0200, 32'h0, 3'b001, 32'h0080_FF11, 32'h0, 4'h0, 32'hFFFF_FF11);
        ls_access("lb1", 1'b0, 32'h0000_0201, 32'h0, 3'b000, 32'h0080_FF11, 32'h0, 4'h0, 32'hFFFF_FFFF);
        ls_access("lw", 1'b0, 32'h0000_0204, 32'h0, 3'b010, 32'h0080_FF11, 32'h0, 4'h0, 32'h0080_FF11);

        ls_misalign("mis_lw", 1'b0, 32'h0000_0102, 3'b010, 1'b0);
        ls_misalign("mis_lh", 1'b0, 32'h0000_0201, 3'b001, 1'b0);
        ls_misalign("mis_sw_ifpend", 1'b1, 32'h0000_0203, 3'b010, 1'b1);

        // Both requesting continuously: LS x4 then IF, repeated
        tick();
        i_if_req = 1'b1; i_if_addr = 32'h0000_0600;
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h0000_0500; i_ls_type_access = 3'b010;
        for (int g = 0; g < 10; g++) begin
            int w;
            got = 2'b00;
            w = 0;
            while (got == 2'b00 && w < 8) begin
                #1;
                got = {o_if_gnt, o_ls_gnt};
                if (got == 2'b00) tick();
                w++;
            end
            check("arb_order", got, exp_seq[g]);
            if (got == 2'b00) break;
            tick();
            i_mem_rvalid = 1'b1;
            #1;
            check("arb_busy_no_gnt", {o_if_gnt, o_ls_gnt}, 0);
            tick();
            i_mem_rvalid = 1'b0;
        end
        i_if_req = 1'b0; i_ls_req = 1'b0;
        tick();

        // Reset mid LS_BUSY, late completion dropped
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h0000_0300; i_ls_type_access = 3'b010;
        #1;
        check("rst_pre_gnt", o_ls_gnt, 1'b1);
        tick();
        i_ls_req = 1'b0;
        #1;
        check("rst_pre_busy", o_busy, 1'b1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678;
        #1;
        check("rst_late_rvalid_in_rst", o_ls_rvalid, 1'b0);
        i_rst_n = 1'b1;
        tick();
        #1;
        check("rst_late_rvalid", {o_ls_rvalid, o_if_rvalid, o_busy}, 0);
        i_mem_rvalid = 1'b0;
        i_if_req = 1'b1; i_if_addr = 32'h0000_0400;
        #1;
        check("rst_if_gnt", {o_if_gnt, o_mem_req}, 2'b11);
        check("rst_if_addr", o_mem_addr, 32'h0000_0400);
        tick();
        i_if_req = 1'b0;
        tick();
        tick();
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
        #1;
        check("rst_if_rdata", {31'h0, o_if_rvalid} ^ o_if_rdata, 32'hCAFE_F00C);
        tick();
        i_mem_rvalid = 1'b0;
        #1;
        check("final_idle", o_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
